prog_loader: RTL and testbench

Boot-time program loader for the albaCore multicycle CPU. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them to instruction/data memory at consecutive addresses from 0. While loading it holds the core in reset, and it releases the core only after the frame checksum verifies.

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a framed byte
// stream, writes them from address 0 and releases the core once the checksum matches.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              load_req_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_din_o,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    // state     | meaning
    // HDR_HI    | waiting for word count high byte
    // HDR_LO    | waiting for word count low byte, then range check
    // DATA_HI   | waiting for instruction word high byte
    // DATA_LO   | waiting for instruction word low byte
    // WRITE     | one-cycle memory write strobe
    // CKSUM     | waiting for checksum byte
    // DONE      | load good, core released
    // ERROR     | bad checksum or oversize header, core held
    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CKSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         word_q, word_d;
    logic [7:0]          sum_q, sum_d;
    logic                accept;
    logic [15:0]         hdr_n;

    assign accept = in_valid_i && in_ready_o;
    assign hdr_n  = {count_q[15:8], in_data_i};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR_HI;
            count_q     <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        word_d      = word_q;
        sum_d       = sum_q;
        case (state_q)
            S_HDR_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data_i;
                    sum_d         = sum_q + in_data_i;
                    state_d       = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    count_d     = hdr_n;
                    remaining_d = hdr_n;
                    sum_d       = sum_q + in_data_i;
                    if ({1'b0, hdr_n} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = S_CKSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    word_d[15:8] = in_data_i;
                    sum_d        = sum_q + in_data_i;
                    state_d      = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    word_d[7:0] = in_data_i;
                    sum_d       = sum_q + in_data_i;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // remaining acts as a down-counter; terminal count ends the data phase
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? S_CKSUM : S_DATA_HI;
            end
            S_CKSUM: begin
                if (accept) begin
                    state_d = (in_data_i == sum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (load_req_i) begin
                    state_d     = S_HDR_HI;
                    count_d     = '0;
                    remaining_d = '0;
                    addr_d      = '0;
                    word_d      = '0;
                    sum_d       = '0;
                end
            end
            default: state_d = S_HDR_HI;
        endcase
    end

    assign in_ready_o   = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                          (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                          (state_q == S_CKSUM);
    assign mem_we_o     = (state_q == S_WRITE);
    assign mem_addr_o   = addr_q;
    assign mem_din_o    = word_q;
    assign core_reset_o = (state_q != S_DONE);
    assign busy_o       = (state_q != S_DONE) && (state_q != S_ERROR);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frames for prog_loader, checked against a frame-level
// model of expected writes, outcome and latency.
module tb_prog_loader;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  frame[$];
    logic [23:0] wr_q[$];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .load_req_i   (load_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .core_reset_o (core_reset),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_din});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte after an optional idle gap and returns the cycle it was taken.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int k;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            load_req = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        load_req = ($urandom_range(0, 3) == 0);
        for (k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [15:0] nn;
        logic [7:0]  s;
        nn = 16'(n);
        frame.delete();
        frame.push_back(nn[15:8]);
        frame.push_back(nn[7:0]);
        if (n <= (1 << ADDR_W)) begin
            for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom_range(0, 255)));
            s = 8'd0;
            foreach (frame[i]) s = s + frame[i];
            frame.push_back(corrupt ? s + 8'd1 : s);
        end
    endtask

    // Sends the frame held in 'frame' and checks writes, outcome and latency.
    task automatic run_frame(input string tag, input int maxgap);
        int      n;
        int      nbytes;
        bit      oversize;
        int      sum;
        bit      good;
        int      first_c;
        int      last_c;
        int      c;
        logic [23:0] exp_w;
        n        = {frame[0], frame[1]};
        oversize = (n > (1 << ADDR_W));
        nbytes   = oversize ? 2 : 2 * n + 3;
        sum      = 0;
        for (int i = 0; i < 2 * n + 2 && !oversize; i++) sum = (sum + frame[i]) % 256;
        good     = !oversize && (frame[2 * n + 2] == 8'(sum));
        wr_q.delete();
        first_c  = 0;
        last_c   = 0;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frame[i], (i == 0) ? 0 : $urandom_range(0, maxgap), c);
            if (i == 0) first_c = c;
            last_c = c;
        end
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
        chk({tag, ".done"},       {31'd0, done},       {31'd0, good});
        chk({tag, ".error"},      {31'd0, error},      {31'd0, !good});
        chk({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, !good});
        chk({tag, ".busy"},       {31'd0, busy},       32'd0);
        chk({tag, ".in_ready"},   {31'd0, in_ready},   32'd0);
        chk({tag, ".nwrites"},    wr_q.size(),         oversize ? 0 : n);
        for (int i = 0; i < n && !oversize && i < wr_q.size(); i++) begin
            exp_w = {8'(i % (1 << ADDR_W)), frame[2 + 2 * i], frame[3 + 2 * i]};
            chk($sformatf("%s.wr%0d", tag, i), {8'd0, wr_q[i]}, {8'd0, exp_w});
        end
        if (maxgap == 0 && !oversize) chk({tag, ".latency"}, last_c - first_c, 3 * n + 2);
        // DONE/ERROR must hold with in_valid high and no load_req
        @(negedge clk);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".hold"}, {30'd0, done, error}, {30'd0, good, !good});
    endtask

    task automatic restart(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk({tag, ".busy"},       {31'd0, busy},       32'd1);
        chk({tag, ".core_reset"}, {31'd0, core_reset}, 32'd1);
        chk({tag, ".flags"},      {30'd0, done, error}, 32'd0);
        chk({tag, ".in_ready"},   {31'd0, in_ready},   32'd1);
        chk({tag, ".addr"},       {24'd0, mem_addr},   32'd0);
    endtask

    initial begin
        int c;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst.mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst.mem_addr",   {24'd0, mem_addr},   32'd0);
        chk("rst.mem_din",    {16'd0, mem_din},    32'd0);
        chk("rst.outs",       {28'd0, core_reset, busy, done, error}, 32'hC);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst.outs",  {28'd0, core_reset, busy, done, error}, 32'hC);

        frame = '{8'h00, 8'h02, 8'h71, 8'h23, 8'hA0, 8'h05, 8'h3B};
        run_frame("good", 0);
        chk("good.wr0_lit", {8'd0, wr_q[0]}, 32'h007123);
        chk("good.wr1_lit", {8'd0, wr_q[1]}, 32'h01A005);
        restart("restart1");

        frame = '{8'h00, 8'h02, 8'h71, 8'h23, 8'hA0, 8'h05, 8'h3C};
        run_frame("badck", 0);
        restart("restart2");

        frame = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", 0);
        restart("restart3");

        frame = '{8'h01, 8'h01};
        run_frame("oversize", 0);
        restart("restart4");

        frame = '{8'h00, 8'h02, 8'h71, 8'h23, 8'hA0, 8'h05, 8'h3B};
        run_frame("bp", 2);
        restart("restart5");

        build_frame(1 << ADDR_W, 1'b0);
        run_frame("maxlen", 0);
        restart("restart6");

        build_frame((1 << ADDR_W) + 1, 1'b0);
        run_frame("over_by_one", 0);
        restart("restart7");

        for (int it = 0; it < 12; it++) begin
            build_frame($urandom_range(0, 6), ($urandom_range(0, 2) == 0));
            run_frame($sformatf("rnd%0d", it), $urandom_range(0, 3));
            restart($sformatf("rnd%0d.re", it));
        end

        // reset after the 4th data byte aborts the load
        frame = '{8'h00, 8'h02, 8'h71, 8'h23, 8'hA0, 8'h05, 8'h3B};
        wr_q.delete();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0, c);
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.in_ready", {31'd0, in_ready},   32'd1);
        chk("midrst.mem_addr", {24'd0, mem_addr},   32'd0);
        chk("midrst.outs",     {28'd0, core_reset, busy, done, error}, 32'hC);
        chk("midrst.nwrites",  wr_q.size(),         32'd2);

        frame = '{8'h00, 8'h02, 8'h71, 8'h23, 8'hA0, 8'h05, 8'h3B};
        run_frame("after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
